// File: rtl/sram_port_ctrl_if.sv
// Request/response and bridge pin bundle for sram_port_ctrl.
// master = clients plus bridge side, slave = the controller.
interface sram_port_ctrl_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 64
);
   logic              io_wr_valid;
   logic              io_wr_ready;
   logic [ADDR_W-1:0] io_wr_addr;
   logic [DATA_W-1:0] io_wr_data;

   logic              io_rd0_req_valid;
   logic              io_rd0_req_ready;
   logic [ADDR_W-1:0] io_rd0_req_addr;
   logic              io_rd0_resp_valid;
   logic              io_rd0_resp_ready;
   logic [DATA_W-1:0] io_rd0_resp_data;

   logic              io_rd1_req_valid;
   logic              io_rd1_req_ready;
   logic [ADDR_W-1:0] io_rd1_req_addr;
   logic              io_rd1_resp_valid;
   logic              io_rd1_resp_ready;
   logic [DATA_W-1:0] io_rd1_resp_data;

   logic              io_ram_we;
   logic [ADDR_W-1:0] io_ram_wr_addr;
   logic [DATA_W-1:0] io_ram_din;
   logic              io_ram_re;
   logic [ADDR_W-1:0] io_ram_rd_addr;
   logic              io_ram_re2;
   logic [ADDR_W-1:0] io_ram_rd_addr2;
   logic [DATA_W-1:0] io_ram_dout;
   logic [DATA_W-1:0] io_ram_dout2;

   modport master (
      output io_wr_valid, io_wr_addr, io_wr_data,
      input  io_wr_ready,
      output io_rd0_req_valid, io_rd0_req_addr,
      input  io_rd0_req_ready,
      input  io_rd0_resp_valid, io_rd0_resp_data,
      output io_rd0_resp_ready,
      output io_rd1_req_valid, io_rd1_req_addr,
      input  io_rd1_req_ready,
      input  io_rd1_resp_valid, io_rd1_resp_data,
      output io_rd1_resp_ready,
      input  io_ram_we, io_ram_wr_addr, io_ram_din,
      input  io_ram_re, io_ram_rd_addr,
      input  io_ram_re2, io_ram_rd_addr2,
      output io_ram_dout, io_ram_dout2
   );

   modport slave (
      input  io_wr_valid, io_wr_addr, io_wr_data,
      output io_wr_ready,
      input  io_rd0_req_valid, io_rd0_req_addr,
      output io_rd0_req_ready,
      output io_rd0_resp_valid, io_rd0_resp_data,
      input  io_rd0_resp_ready,
      input  io_rd1_req_valid, io_rd1_req_addr,
      output io_rd1_req_ready,
      output io_rd1_resp_valid, io_rd1_resp_data,
      input  io_rd1_resp_ready,
      output io_ram_we, io_ram_wr_addr, io_ram_din,
      output io_ram_re, io_ram_rd_addr,
      output io_ram_re2, io_ram_rd_addr2,
      input  io_ram_dout, io_ram_dout2
   );
endinterface

// File: rtl/sram_port_ctrl.sv
// Request-side controller for the dual-read/single-write SRAM bridge.
// Define SRAM_CTRL_FWD_EN to forward same-cycle write data instead of stalling.
module sram_port_ctrl #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 64,
   parameter int RESP_DEPTH = 4
) (
   input logic             io_clk,
   input logic             io_reset,
   sram_port_ctrl_if.slave bus
);
   localparam int PW = $clog2(RESP_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(RESP_DEPTH);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic              wr_acc;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0]        req_acc;
   logic [1:0]        resp_valid;
   logic [1:0]        resp_ready;
   logic [ADDR_W-1:0] req_addr  [2];
   logic [DATA_W-1:0] ram_dout  [2];
   logic [DATA_W-1:0] resp_data [2];

   assign wr_acc         = bus.io_wr_valid && !io_reset;
   assign bus.io_wr_ready = !io_reset;
   assign bus.io_ram_we   = wr_acc;
   assign bus.io_ram_wr_addr = wr_acc ? bus.io_wr_addr : '0;
   assign bus.io_ram_din  = wr_acc ? bus.io_wr_data : '0;

   assign req_valid   = {bus.io_rd1_req_valid, bus.io_rd0_req_valid};
   assign resp_ready  = {bus.io_rd1_resp_ready, bus.io_rd0_resp_ready};
   assign req_addr[0] = bus.io_rd0_req_addr;
   assign req_addr[1] = bus.io_rd1_req_addr;
   assign ram_dout[0] = bus.io_ram_dout;
   assign ram_dout[1] = bus.io_ram_dout2;

   assign bus.io_ram_re       = req_acc[0];
   assign bus.io_ram_rd_addr  = req_acc[0] ? req_addr[0] : '0;
   assign bus.io_ram_re2      = req_acc[1];
   assign bus.io_ram_rd_addr2 = req_acc[1] ? req_addr[1] : '0;

   assign bus.io_rd0_req_ready  = req_ready[0];
   assign bus.io_rd1_req_ready  = req_ready[1];
   assign bus.io_rd0_resp_valid = resp_valid[0];
   assign bus.io_rd1_resp_valid = resp_valid[1];
   assign bus.io_rd0_resp_data  = resp_data[0];
   assign bus.io_rd1_resp_data  = resp_data[1];

   for (genvar p = 0; p < 2; p++) begin : g_port
      logic [CW-1:0]     credits;
      logic [CW-1:0]     wp;
      logic [CW-1:0]     rp;
      logic [1:0]        stg;
      logic [DATA_W-1:0] fifo [RESP_DEPTH];
      logic [DATA_W-1:0] push_data;
      logic              hit;
      logic              stall;
      logic              resp_acc;

      assign hit = wr_acc && req_valid[p] &&
                   (bus.io_wr_addr == req_addr[p]);

`ifdef SRAM_CTRL_FWD_EN
      logic [1:0]        hz;
      logic [DATA_W-1:0] fwd_data [2];

      // Bridge reads old data on a same-cycle hit; replay the write word.
      assign stall     = 1'b0;
      assign push_data = hz[1] ? fwd_data[1] : ram_dout[p];

      always_ff @(posedge io_clk) begin
         if (io_reset) begin
            hz <= '0;
         end else begin
            hz <= {hz[0], hit && req_acc[p]};
         end
      end

      always_ff @(posedge io_clk) begin
         fwd_data[0] <= bus.io_wr_data;
         fwd_data[1] <= fwd_data[0];
      end
`else
      assign stall     = hit;
      assign push_data = ram_dout[p];
`endif

      assign req_ready[p] = !io_reset && (credits < FULL) && !stall;
      assign req_acc[p]   = req_valid[p] && req_ready[p];
      assign resp_valid[p] = !io_reset && (wp != rp);
      assign resp_acc     = resp_valid[p] && resp_ready[p];
      assign resp_data[p] = fifo[rp[PW-1:0]];

      always_ff @(posedge io_clk) begin
         if (io_reset) begin
            credits <= '0;
            stg     <= '0;
            wp      <= '0;
            rp      <= '0;
         end else begin
            stg <= {stg[0], req_acc[p]};
            if (stg[1]) wp <= wp + ONE;
            if (resp_acc) rp <= rp + ONE;
            if (req_acc[p] && !resp_acc) begin
               credits <= credits + ONE;
            end else if (!req_acc[p] && resp_acc) begin
               credits <= credits - ONE;
            end
         end
      end

      // Credits bound occupancy, so a push never lands on a live entry.
      always_ff @(posedge io_clk) begin
         if (stg[1] && !io_reset) begin
            fifo[wp[PW-1:0]] <= push_data;
         end
      end
   end
endmodule

// File: tb/tb_sram_port_ctrl.sv
// Randomized bench for sram_port_ctrl with a queue-based response model.
// Includes a 2-cycle-latency bridge model driving the read data pins.
module tb_sram_port_ctrl;
   localparam int AW = 4;
   localparam int DW = 64;
   localparam int D  = 4;
`ifdef SRAM_CTRL_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct {
      logic [DW-1:0] d;
      int            t;
   } rsp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sram_port_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   sram_port_ctrl #(
      .ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(D)
   ) dut (
      .io_clk(clk),
      .io_reset(rst),
      .bus(bus)
   );

   logic [DW-1:0] bmem [16];
   logic [DW-1:0] p1   [2];

   always @(posedge clk) begin
      if (bus.io_ram_we) bmem[bus.io_ram_wr_addr] <= bus.io_ram_din;
      p1[0] <= bmem[bus.io_ram_rd_addr];
      p1[1] <= bmem[bus.io_ram_rd_addr2];
      bus.io_ram_dout  <= p1[0];
      bus.io_ram_dout2 <= p1[1];
   end

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   logic [DW-1:0] mem_m [16];
   rsp_t q [2][$];
   logic [1:0] last_acc;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic idle();
      bus.io_wr_valid = 1'b0;
      bus.io_wr_addr  = '0;
      bus.io_wr_data  = '0;
      bus.io_rd0_req_valid = 1'b0;
      bus.io_rd0_req_addr  = '0;
      bus.io_rd1_req_valid = 1'b0;
      bus.io_rd1_req_addr  = '0;
      bus.io_rd0_resp_ready = 1'b1;
      bus.io_rd1_resp_ready = 1'b1;
   endtask

   task automatic tick();
      logic          wacc;
      logic [1:0]    rv, rr, rdy, acc, ev;
      logic [AW-1:0] ra [2];
      logic [AW-1:0] wa;
      logic [DW-1:0] wd, ed;
      logic          hz;
      logic          rst_s;
      #3;
      rst_s = rst;
      wa    = bus.io_wr_addr;
      wd    = bus.io_wr_data;
      wacc  = bus.io_wr_valid && !rst_s;
      rv    = {bus.io_rd1_req_valid, bus.io_rd0_req_valid};
      rr    = {bus.io_rd1_resp_ready, bus.io_rd0_resp_ready};
      ra[0] = bus.io_rd0_req_addr;
      ra[1] = bus.io_rd1_req_addr;
      for (int p = 0; p < 2; p++) begin
         hz     = wacc && rv[p] && (wa == ra[p]);
         rdy[p] = !rst_s && (q[p].size() < D) && !(hz && !FWD);
         acc[p] = rv[p] && rdy[p];
         ev[p]  = !rst_s && (q[p].size() > 0) && (q[p][0].t + 3 <= cyc);
      end
      check("wr_ready", 64'(bus.io_wr_ready), 64'(!rst_s));
      check("ram_we", 64'(bus.io_ram_we), 64'(wacc));
      check("ram_wr_addr", 64'(bus.io_ram_wr_addr), wacc ? 64'(wa) : 64'd0);
      check("ram_din", bus.io_ram_din, wacc ? wd : 64'd0);
      check("rd0_req_ready", 64'(bus.io_rd0_req_ready), 64'(rdy[0]));
      check("rd1_req_ready", 64'(bus.io_rd1_req_ready), 64'(rdy[1]));
      check("ram_re", 64'(bus.io_ram_re), 64'(acc[0]));
      check("ram_re2", 64'(bus.io_ram_re2), 64'(acc[1]));
      check("ram_rd_addr", 64'(bus.io_ram_rd_addr),
            acc[0] ? 64'(ra[0]) : 64'd0);
      check("ram_rd_addr2", 64'(bus.io_ram_rd_addr2),
            acc[1] ? 64'(ra[1]) : 64'd0);
      check("rd0_resp_valid", 64'(bus.io_rd0_resp_valid), 64'(ev[0]));
      check("rd1_resp_valid", 64'(bus.io_rd1_resp_valid), 64'(ev[1]));
      if (ev[0]) check("rd0_resp_data", bus.io_rd0_resp_data, q[0][0].d);
      if (ev[1]) check("rd1_resp_data", bus.io_rd1_resp_data, q[1][0].d);
      @(posedge clk);
      if (rst_s) begin
         q[0].delete();
         q[1].delete();
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (ev[p] && rr[p]) void'(q[p].pop_front());
            if (acc[p]) begin
               ed = (wacc && wa == ra[p]) ? wd : mem_m[ra[p]];
               q[p].push_back('{d: ed, t: cyc});
            end
         end
         if (wacc) mem_m[wa] = wd;
      end
      last_acc = acc;
      cyc++;
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.io_wr_valid = 1'b1;
      bus.io_wr_addr  = a;
      bus.io_wr_data  = d;
      tick();
      bus.io_wr_valid = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      idle();
      #1;
      tick();
      tick();
      rst = 1'b0;

      do_write(4'd3, 64'hDEAD_BEEF_0123_4567);
      tick();
      bus.io_rd0_req_valid = 1'b1;
      bus.io_rd0_req_addr  = 4'd3;
      tick();
      check("first_read_accept", 64'(last_acc[0]), 64'd1);
      bus.io_rd0_req_valid = 1'b0;
      repeat (5) tick();

      for (int a = 0; a < 16; a++) do_write(AW'(a), 64'(a) * 64'h1111);
      for (int i = 0; i < 16; i++) begin
         bus.io_rd0_req_valid = 1'b1;
         bus.io_rd0_req_addr  = AW'(i);
         bus.io_rd1_req_valid = 1'b1;
         bus.io_rd1_req_addr  = AW'(15 - i);
         tick();
      end
      idle();
      repeat (6) tick();

      bus.io_rd1_resp_ready = 1'b0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         bus.io_rd1_req_valid = 1'b1;
         bus.io_rd1_req_addr  = AW'(n);
         tick();
         if (last_acc[1]) n++;
      end
      check("bp_accepts", 64'(n), 64'd4);
      bus.io_rd1_req_valid  = 1'b0;
      bus.io_rd1_resp_ready = 1'b1;
      repeat (7) tick();

      do_write(4'd5, {16{4'h5}});
      bus.io_wr_valid = 1'b1;
      bus.io_wr_addr  = 4'd5;
      bus.io_wr_data  = {16{4'hA}};
      bus.io_rd0_req_valid = 1'b1;
      bus.io_rd0_req_addr  = 4'd5;
      tick();
      check("hazard_accept", 64'(last_acc[0]), 64'(FWD));
      bus.io_wr_valid = 1'b0;
      if (!last_acc[0]) tick();
      bus.io_rd0_req_valid = 1'b0;
      repeat (5) tick();

      bus.io_rd0_resp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.io_rd0_req_valid = 1'b1;
         bus.io_rd0_req_addr  = AW'(i + 8);
         tick();
      end
      bus.io_rd0_req_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.io_rd0_resp_ready = 1'b1;
      repeat (5) tick();
      bus.io_rd0_resp_ready = 1'b0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         bus.io_rd0_req_valid = 1'b1;
         bus.io_rd0_req_addr  = AW'(i);
         tick();
         if (last_acc[0]) n++;
      end
      check("post_reset_cap", 64'(n), 64'd4);
      idle();
      repeat (6) tick();

      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         bus.io_wr_valid = $urandom_range(0, 1) == 1;
         bus.io_wr_addr  = AW'($urandom_range(0, 15));
         bus.io_wr_data  = {$urandom, $urandom};
         bus.io_rd0_req_valid = $urandom_range(0, 1) == 1;
         bus.io_rd0_req_addr  = AW'($urandom_range(0, 15));
         bus.io_rd1_req_valid = $urandom_range(0, 1) == 1;
         bus.io_rd1_req_addr  = AW'($urandom_range(0, 15));
         bus.io_rd0_resp_ready = $urandom_range(0, 3) != 0;
         bus.io_rd1_resp_ready = $urandom_range(0, 3) != 0;
         tick();
      end
      rst = 1'b0;
      idle();
      repeat (8) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
